// File: rtl/useq_pkg.sv
// Shared types and default sizes for the micro-sequencer next-address stage.
// Contents: microword opcode enum, default widths/depth, stack-pointer width helper.
// No logic lives here.
package useq_pkg;

  typedef enum logic [2:0] {
    NEXT  = 3'd0,
    JUMP  = 3'd1,
    BRZ   = 3'd2,
    CALL  = 3'd3,
    RET   = 3'd4,
    LDCNT = 3'd5,
    LOOP  = 3'd6,
    WAIT  = 3'd7
  } uop_t;

  localparam int UPC_W_DFLT = 5;
  localparam int CNT_W_DFLT = 4;
  localparam int DEPTH_DFLT = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/useq_next_if.sv
// Bundle between the microcode ROM / upc register side and the next-address stage.
// master: drives en/upc/microword fields/cond_z/ready, receives the decision.
// slave:  the sequencer, drives load_incr/upc_next/sp/waiting/err.
interface useq_next_if
  import useq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DFLT,
  parameter int UPC_W = UPC_W_DFLT,
  parameter int CNT_W = CNT_W_DFLT
);
  localparam int SP_W = sp_width(DEPTH);

  logic             en;
  logic [UPC_W-1:0] upc;
  uop_t             uop;
  logic [UPC_W-1:0] uaddr;
  logic [CNT_W-1:0] ucnt;
  logic             cond_z;
  logic             ready;
  logic             load_incr;
  logic [UPC_W-1:0] upc_next;
  logic [SP_W-1:0]  sp;
  logic             waiting;
  logic             err;

  modport master (
    output en, upc, uop, uaddr, ucnt, cond_z, ready,
    input  load_incr, upc_next, sp, waiting, err
  );

  modport slave (
    input  en, upc, uop, uaddr, ucnt, cond_z, ready,
    output load_incr, upc_next, sp, waiting, err
  );

endinterface

// File: rtl/useq_stack.sv
// Return-address LIFO: push/pop/din in, top/sp/full/empty out.
// Push and pop take effect on the clock edge; top is combinational from stack[sp-1].
// A push when full or a pop when empty is ignored; the parent reports the error.
module useq_stack
  import useq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DFLT,
  parameter int W     = UPC_W_DFLT,
  parameter int SP_W  = sp_width(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    top,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Only reached when not full, so sp always fits the index width here.
  assign wr_idx  = IDX_W'(sp);
  // Wraps harmlessly when empty; top is not consumed in that case.
  assign rd_idx  = IDX_W'(sp - 1'b1);
  assign top     = mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + 1'b1;
    end else if (do_pop) begin
      sp <= sp - 1'b1;
    end
  end

  // Contents need no reset: anything above sp is never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/useq_next.sv
// Micro-sequencer next-address stage: chooses increment/jump/call/return/loop/hold for the upc register.
// Ports: clk, reset (async, active-high), bus (useq_next_if.slave) carrying microword, flags and decision.
// Decision is combinational (same cycle); sp/cnt/err/stack update on the posedge. Hold = load upc.
module useq_next
  import useq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DFLT,
  parameter int UPC_W = UPC_W_DFLT,
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  useq_next_if.slave  bus
);
  localparam int SP_W = sp_width(DEPTH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_set;
  logic             push;
  logic             pop;
  logic [UPC_W-1:0] ret_addr;
  logic [UPC_W-1:0] stk_top;
  logic [SP_W-1:0]  stk_sp;
  logic             stk_full;
  logic             stk_empty;
  logic             load_incr;
  logic [UPC_W-1:0] upc_next;
  logic             waiting;

  // Return address wraps naturally at the UPC_W boundary.
  assign ret_addr = bus.upc + 1'b1;

  always_comb begin
    // Default is hold: the counter has no hold mode, so reload the current upc.
    load_incr = 1'b1;
    upc_next  = bus.upc;
    waiting   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    cnt_d     = cnt;
    err_set   = 1'b0;

    if (reset) begin
      upc_next = '0;
    end else if (bus.en) begin
      case (bus.uop)
        NEXT: load_incr = 1'b0;
        JUMP: upc_next  = bus.uaddr;
        BRZ: begin
          if (bus.cond_z) upc_next  = bus.uaddr;
          else            load_incr = 1'b0;
        end
        CALL: begin
          if (!stk_full) begin
            push     = 1'b1;
            upc_next = bus.uaddr;
          end else begin
            err_set   = 1'b1;
            load_incr = 1'b0;
          end
        end
        RET: begin
          if (!stk_empty) begin
            pop      = 1'b1;
            upc_next = stk_top;
          end else begin
            err_set   = 1'b1;
            load_incr = 1'b0;
          end
        end
        LDCNT: begin
          cnt_d     = bus.ucnt;
          load_incr = 1'b0;
        end
        LOOP: begin
          // Exhausted counter falls through and stays at zero.
          if (cnt != '0) begin
            cnt_d    = cnt - 1'b1;
            upc_next = bus.uaddr;
          end else begin
            load_incr = 1'b0;
          end
        end
        WAIT: begin
          if (bus.ready) load_incr = 1'b0;
          else           waiting   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= cnt_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  useq_stack #(
    .DEPTH (DEPTH),
    .W     (UPC_W),
    .SP_W  (SP_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .top   (stk_top),
    .sp    (stk_sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.load_incr = load_incr;
  assign bus.upc_next  = upc_next;
  assign bus.waiting   = waiting;
  assign bus.sp        = stk_sp;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_useq_next.sv
// Directed bench for useq_next with a scoreboard queue.
// Stimulus drives one microword per cycle just after posedge and queues the expected decision.
// Monitor pops and compares at each negedge while an expectation is pending.
module tb_useq_next;
  import useq_pkg::*;

  localparam int DEPTH = 4;
  localparam int UPC_W = 5;
  localparam int CNT_W = 4;
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  useq_next_if #(.DEPTH(DEPTH), .UPC_W(UPC_W), .CNT_W(CNT_W)) bus ();

  useq_next #(.DEPTH(DEPTH), .UPC_W(UPC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string            name;
    logic             li;
    logic [UPC_W-1:0] un;
    logic             w;
    logic [SP_W-1:0]  sp;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string fld, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp_v);
    end
  endtask

  // Arguments: name, upc, opcode, uaddr, expected load_incr, expected upc_next
  // (checked only when loading), expected sp, expected err, expected waiting,
  // then en, ready, cond_z, ucnt, reset.
  task automatic step(input string name, input int upc, input uop_t op, input int ua,
                      input int li, input int un, input int sp, input int err,
                      input int w = 0, input int en = 1, input int rdy = 1,
                      input int cz = 0, input int uc = 0, input int rst = 0);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst[0];
    bus.en     = en[0];
    bus.upc    = UPC_W'(upc);
    bus.uop    = op;
    bus.uaddr  = UPC_W'(ua);
    bus.ucnt   = CNT_W'(uc);
    bus.cond_z = cz[0];
    bus.ready  = rdy[0];
    e.name = name;
    e.li   = li[0];
    e.un   = UPC_W'(un);
    e.w    = w[0];
    e.sp   = SP_W'(sp);
    e.err  = err[0];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "load_incr", int'(bus.load_incr), int'(e.li));
      if (e.li) chk(e.name, "upc_next", int'(bus.upc_next), int'(e.un));
      chk(e.name, "waiting", int'(bus.waiting), int'(e.w));
      chk(e.name, "sp", int'(bus.sp), int'(e.sp));
      chk(e.name, "err", int'(bus.err), int'(e.err));
    end
  end

  initial begin
    bus.en     = 1'b0;
    bus.upc    = '0;
    bus.uop    = NEXT;
    bus.uaddr  = '0;
    bus.ucnt   = '0;
    bus.cond_z = 1'b0;
    bus.ready  = 1'b0;

    // Reset held over a stalled WAIT: reset outputs, nothing waiting.
    step("rst_init",  7, WAIT, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    // Call and return.
    step("call_3",    3, CALL, 20, 1, 20, 0, 0);
    step("nx_20",    20, NEXT,  0, 0,  0, 1, 0);
    step("ret_4",    21, RET,   0, 1,  4, 1, 0);
    step("nx_4",      4, NEXT,  0, 0,  0, 0, 0);
    // Branch.
    step("brz_nz",    4, BRZ,   9, 0,  0, 0, 0, 0, 1, 1, 0);
    step("brz_z",     5, BRZ,   9, 1,  9, 0, 0, 0, 1, 1, 1);
    // Loop: count 2 gives two taken iterations then fall-through.
    step("ldcnt",     9, LDCNT, 0, 0,  0, 0, 0, 0, 1, 1, 0, 2);
    step("loop_a",   10, LOOP,  8, 1,  8, 0, 0);
    step("loop_b",   10, LOOP,  8, 1,  8, 0, 0);
    step("loop_c",   10, LOOP,  8, 0,  0, 0, 0);
    step("loop_d",   11, LOOP,  8, 0,  0, 0, 0);
    // WAIT handshake.
    for (int i = 0; i < 3; i++)
      step("wait_hold", 12, WAIT, 0, 1, 12, 0, 0, 1, 1, 0);
    step("wait_go",  12, WAIT,  0, 0,  0, 0, 0, 0, 1, 1);
    // Freeze during CALL: hold, no push.
    step("frz_call", 13, CALL, 25, 1, 13, 0, 0, 0, 0);
    step("nx_13",    13, NEXT,  0, 0,  0, 0, 0);
    // Return address wraps 31+1 -> 0.
    step("call_31",  31, CALL,  2, 1,  2, 0, 0);
    step("nx_2",      2, NEXT,  0, 0,  0, 1, 0);
    step("ret_wrap",  3, RET,   0, 1,  0, 1, 0);
    step("jump",      0, JUMP, 17, 1, 17, 0, 0);
    // Overflow: the fifth nested CALL is refused.
    step("call_1",    1, CALL, 10, 1, 10, 0, 0);
    step("call_2",   10, CALL, 11, 1, 11, 1, 0);
    step("call_3n",  11, CALL, 12, 1, 12, 2, 0);
    step("call_4",   12, CALL, 13, 1, 13, 3, 0);
    step("call_5",   13, CALL, 14, 0,  0, 4, 0);
    step("nx_ovf",   14, NEXT,  0, 0,  0, 4, 1);
    // Unwind: the refused push must not have overwritten the top.
    step("ret_a",    14, RET,   0, 1, 13, 4, 1);
    step("ret_b",    13, RET,   0, 1, 12, 3, 1);
    step("ret_c",    12, RET,   0, 1, 11, 2, 1);
    step("ret_d",    11, RET,   0, 1,  2, 1, 1);
    step("nx_empty",  2, NEXT,  0, 0,  0, 0, 1);
    // Reset mid-WAIT clears err and the stall.
    step("wait_pre",  3, WAIT,  0, 1,  3, 0, 1, 1, 1, 0);
    step("rst_wait",  3, WAIT,  0, 1,  0, 0, 0, 0, 1, 0, 0, 0, 1);
    // Underflow.
    step("ret_uf",    0, RET,   0, 0,  0, 0, 0);
    step("nx_uf",     1, NEXT,  0, 0,  0, 0, 1);
    // Freeze overrides WAIT.
    step("frz_wait",  2, WAIT,  0, 1,  2, 0, 1, 0, 0, 0);

    begin : drain
      int budget;
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
